async_fifo_gray: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 17 +
 rtl/fifo_sync_bus.sv | 18 +
 rtl/async_fifo_gray.sv | 103 ++++++++++
 tb/tb_async_fifo_gray.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: Gray-code helpers and shared constants for the dual-clock FIFO.
package async_fifo_pkg;
    localparam int GRAY_MAX_W = 16;
    localparam int SYNC_STAGES_MIN = 2;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Callers zero-extend narrower pointers, so the unused upper bits do not disturb the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) b ^= g >> i;
        return b;
    endfunction
endpackage

// File: rtl/fifo_sync_bus.sv
// fifo_sync_bus: STAGES-deep N-bit flop chain with asynchronous reset, for pointer and reset synchronisation.
module fifo_sync_bus #(
    parameter int N = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [STAGES-1:0][N-1:0] chain;

    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= '0;
        else chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];
endmodule

// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointer crossing, per-domain flags and levels.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky wr_overflow / rd_underflow outputs.
module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH = 56,
    parameter int AEMPTY_TH = 8
) (
    input  logic              clk_w,
    input  logic              clk_r,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_afull,
    output logic [ADDR_W:0]   wr_level,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_level
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic              wr_overflow,
    output logic              rd_underflow
`endif
);
    localparam int PW = ADDR_W + 1;
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic rst_w_n, rst_r_n, wrst, rrst;
    logic wr_acc, rd_acc;
    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_sync, rbin_sync;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_sync, wbin_sync;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Assertion is immediate in both domains; release is retimed to each clock.
    fifo_sync_bus #(.N(1), .STAGES(SYNC_STAGES_MIN)) u_rst_w (.clk(clk_w), .rst(rst), .d(1'b1), .q(rst_w_n));
    fifo_sync_bus #(.N(1), .STAGES(SYNC_STAGES_MIN)) u_rst_r (.clk(clk_r), .rst(rst), .d(1'b1), .q(rst_r_n));
    assign wrst = ~rst_w_n;
    assign rrst = ~rst_r_n;

    fifo_sync_bus #(.N(PW), .STAGES(STAGES)) u_w2r (.clk(clk_r), .rst(rrst), .d(wgray), .q(wgray_sync));
    fifo_sync_bus #(.N(PW), .STAGES(STAGES)) u_r2w (.clk(clk_w), .rst(wrst), .d(rgray), .q(rgray_sync));

    assign wr_acc     = wr_en & ~wr_full;
    assign wbin_next  = wbin + PW'(wr_acc);
    assign wgray_next = PW'(bin2gray(16'(wbin_next)));
    assign rbin_sync  = PW'(gray2bin(16'(rgray_sync)));
    assign wr_level   = wbin - rbin_sync;
    assign wr_afull   = wr_level >= PW'(AFULL_TH);

    // Full when the write pointer is one lap ahead: Gray form differs only in the two MSBs.
    always_ff @(posedge clk_w or posedge wrst)
        if (wrst) begin
            wbin    <= '0;
            wgray   <= '0;
            wr_full <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wgray   <= wgray_next;
            wr_full <= wgray_next == {~rgray_sync[PW-1 -: 2], rgray_sync[PW-3:0]};
        end

    always_ff @(posedge clk_w)
        if (wr_acc) mem[wbin[ADDR_W-1:0]] <= wr_data;

    assign rd_acc     = rd_en & ~rd_empty;
    assign rbin_next  = rbin + PW'(rd_acc);
    assign rgray_next = PW'(bin2gray(16'(rbin_next)));
    assign wbin_sync  = PW'(gray2bin(16'(wgray_sync)));
    assign rd_level   = wbin_sync - rbin;
    assign rd_aempty  = rd_level <= PW'(AEMPTY_TH);

    always_ff @(posedge clk_r or posedge rrst)
        if (rrst) begin
            rbin     <= '0;
            rgray    <= '0;
            rd_empty <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rbin     <= rbin_next;
            rgray    <= rgray_next;
            rd_empty <= rgray_next == wgray_sync;
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rbin[ADDR_W-1:0]];
        end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk_w or posedge wrst)
        if (wrst) wr_overflow <= 1'b0;
        else if (wr_en & wr_full) wr_overflow <= 1'b1;

    always_ff @(posedge clk_r or posedge rrst)
        if (rrst) rd_underflow <= 1'b0;
        else if (rd_en & rd_empty) rd_underflow <= 1'b1;
`endif
endmodule

// File: tb/tb_async_fifo_gray.sv
// tb_async_fifo_gray: directed and scoreboarded checks of async_fifo_gray across two clock ratios.
`timescale 1ns/100ps
module tb_async_fifo_gray;
    logic clk_w = 0, clk_r = 0, rst = 1, wr_en = 0, rd_en = 0;
    logic [7:0] wr_data = 0;
    logic wr_full, wr_afull, rd_valid, rd_empty, rd_aempty;
    logic [6:0] wr_level, rd_level;
    logic [7:0] rd_data;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic wr_overflow, rd_underflow;
`endif
    realtime hw = 5.0, hr = 13.5;
    int checks = 0, failures = 0;
    logic [7:0] q[$];

    async_fifo_gray dut (
        .clk_w(clk_w), .clk_r(clk_r), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull), .wr_level(wr_level),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
        .rd_aempty(rd_aempty), .rd_level(rd_level)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        , .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
`endif
    );

    always #(hw) clk_w = ~clk_w;
    always #(hr) clk_r = ~clk_r;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk_w);
        wr_en = 1;
        wr_data = d;
        @(negedge clk_w);
        wr_en = 0;
    endtask

    task automatic rd(output logic [7:0] d, output logic v);
        @(negedge clk_r);
        rd_en = 1;
        @(negedge clk_r);
        rd_en = 0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic wait_ne(input string tag);
        int n = 0;
        while (rd_empty && n < 20) begin
            @(negedge clk_r);
            n++;
        end
        chk(tag, rd_empty, 0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_wr_full"}, wr_full, 0);
        chk({tag, "_wr_afull"}, wr_afull, 0);
        chk({tag, "_wr_level"}, wr_level, 0);
        chk({tag, "_rd_empty"}, rd_empty, 1);
        chk({tag, "_rd_aempty"}, rd_aempty, 1);
        chk({tag, "_rd_level"}, rd_level, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk({tag, "_wr_overflow"}, wr_overflow, 0);
        chk({tag, "_rd_underflow"}, rd_underflow, 0);
`endif
    endtask

    task automatic run(input int n, input int pw, input int pr);
        q.delete();
        fork
            begin
                int sent = 0, cyc = 0;
                logic acc;
                while (sent < n && cyc < 10 * n + 2000) begin
                    @(negedge clk_w);
                    cyc++;
                    chk("wr_level_le64", wr_level <= 64, 1);
                    wr_en = ($urandom_range(99) < pw);
                    wr_data = 8'($urandom);
                    acc = wr_en && !wr_full;
                    @(posedge clk_w);
                    if (acc) begin
                        q.push_back(wr_data);
                        sent++;
                    end
                end
                @(negedge clk_w);
                wr_en = 0;
                chk("wr_done", sent, n);
            end
            begin
                int got = 0, cyc = 0;
                logic pend = 0;
                logic [7:0] e;
                while (got < n && cyc < 10 * n + 2000) begin
                    @(negedge clk_r);
                    cyc++;
                    chk("rd_valid_seq", rd_valid, pend);
                    if (pend) begin
                        e = (q.size() > 0) ? q.pop_front() : 8'hxx;
                        chk("rd_data_seq", rd_data, e);
                        got++;
                    end
                    chk("rd_level_le64", rd_level <= 64, 1);
                    rd_en = (got < n) && ($urandom_range(99) < pr);
                    pend = rd_en && !rd_empty;
                end
                rd_en = 0;
                chk("rd_done", got, n);
            end
        join
    endtask

    initial begin
        logic [7:0] d, last;
        logic v;
        int n;
        #20;
        reset_vals("por");
        #30 rst = 0;
        repeat (5) @(negedge clk_r);

        // Reset pulse in the middle of traffic.
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        wait_ne("t1_visible");
        rd(d, v);
        chk("t1_first_data", d, 8'h11);
        @(negedge clk_w);
        wr_en = 1;
        wr_data = 8'h44;
        #2 rst = 1;
        #1 reset_vals("t1_async");
        wr_en = 0;
        #30 rst = 0;
        repeat (10) @(negedge clk_r);
        chk("t1_post_empty", rd_empty, 1);
        chk("t1_post_rd_level", rd_level, 0);
        chk("t1_post_wr_level", wr_level, 0);
        rd(d, v);
        chk("t1_post_valid", v, 0);
        chk("t1_post_data", d, 0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("t1_underflow", rd_underflow, 1);
`endif

        // Fill to full with no reads.
        for (int i = 0; i < 64; i++) begin
            wr(8'(i));
            chk("t2_wr_level", wr_level, i + 1);
            chk("t2_wr_afull", wr_afull, (i + 1) >= 56);
            chk("t2_wr_full", wr_full, (i + 1) == 64);
        end
        wr(8'hEE);
        chk("t2_ovf_level", wr_level, 64);
        chk("t2_ovf_full", wr_full, 1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("t2_overflow", wr_overflow, 1);
`endif
        repeat (6) @(negedge clk_r);
        chk("t2_rd_level", rd_level, 64);
        chk("t2_rd_aempty", rd_aempty, 0);
        chk("t2_rd_empty", rd_empty, 0);

        // Drain in order.
        for (int i = 0; i < 64; i++) begin
            rd(d, v);
            chk("t3_data", d, i);
            chk("t3_valid", v, 1);
            chk("t3_rd_aempty", rd_aempty, (63 - i) <= 8);
            chk("t3_rd_empty", rd_empty, i == 63);
        end
        rd(d, v);
        chk("t3_extra_valid", v, 0);
        chk("t3_extra_data", d, 8'h3F);
        repeat (6) @(negedge clk_w);
        chk("t3_wr_level", wr_level, 0);
        chk("t3_wr_full", wr_full, 0);

        // Single word crossing latency.
        wr(8'hA5);
        n = 0;
        while (rd_empty && n < 3) begin
            @(posedge clk_r);
            #1 n++;
        end
        chk("t4_visible_3edges", rd_empty, 0);
        rd(d, v);
        chk("t4_data", d, 8'hA5);
        chk("t4_valid", v, 1);

        // Simultaneous write and read at full: write blocked.
        for (int i = 0; i < 64; i++) wr(8'(i));
        repeat (6) @(negedge clk_r);
        @(negedge clk_r);
        wr_en = 1;
        wr_data = 8'h77;
        rd_en = 1;
        @(posedge clk_w);
        #1 chk("t6_full_level", wr_level, 64);
        chk("t6_full_flag", wr_full, 1);
        wr_en = 0;
        @(negedge clk_r);
        rd_en = 0;
        chk("t6_full_rd_valid", rd_valid, 1);
        chk("t6_full_rd_data", rd_data, 0);
        n = 0;
        last = 0;
        while (!rd_empty && n < 100) begin
            rd(d, v);
            last = d;
            n++;
        end
        chk("t6_drain_count", n, 63);
        chk("t6_drain_last", last, 8'h3F);

        // Simultaneous write and read at empty: read blocked.
        @(negedge clk_r);
        wr_en = 1;
        wr_data = 8'h5A;
        rd_en = 1;
        @(posedge clk_w);
        #1 wr_en = 0;
        @(negedge clk_r);
        chk("t6_empty_rd_valid", rd_valid, 0);
        rd_en = 0;
        wait_ne("t6_empty_visible");
        rd(d, v);
        chk("t6_empty_data", d, 8'h5A);
        chk("t6_empty_valid", v, 1);

        // Sustained back-to-back requests at both ratios.
        run(300, 100, 100);
        hw = 13.5;
        hr = 5.0;
        repeat (4) @(negedge clk_w);
        run(300, 100, 100);

        // Random traffic, 100/37 then 37/100.
        hw = 5.0;
        hr = 13.5;
        repeat (4) @(negedge clk_r);
        run(5000, 60, 70);
        hw = 13.5;
        hr = 5.0;
        repeat (4) @(negedge clk_w);
        run(5000, 60, 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
